// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the loadable program memory.
// The optional per-word parity feature is enabled by PROG_MEM_PARITY_EN.
package prog_mem_pkg;

    localparam int unsigned DEF_DATA_W = 14;
    localparam int unsigned DEF_ADDR_W = 11;

    localparam logic [DEF_DATA_W-1:0] NOP = '0;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    // Even parity bit: callers zero-extend the word, which leaves the XOR unchanged.
    function automatic logic even_par(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/prog_mem_rw_if.sv
// Fetch and load bus of the program memory. fetch_perr exists only with PROG_MEM_PARITY_EN.
interface prog_mem_rw_if
    import prog_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
`ifdef PROG_MEM_PARITY_EN
    logic              fetch_perr;
`endif
    logic              cpu_hold;
    logic              prog_start;
    logic [ADDR_W-1:0] prog_base;
    logic              prog_valid;
    logic [DATA_W-1:0] prog_data;
    logic              prog_last;
    logic              prog_ready;
    logic              prog_done;
    logic              prog_wrap;
    logic [DATA_W-1:0] prog_csum;

    modport master (
`ifdef PROG_MEM_PARITY_EN
        input  fetch_perr,
`endif
        output fetch_en, fetch_addr, prog_start, prog_base, prog_valid, prog_data, prog_last,
        input  fetch_data, fetch_valid, cpu_hold, prog_ready, prog_done, prog_wrap, prog_csum
    );

    modport slave (
`ifdef PROG_MEM_PARITY_EN
        output fetch_perr,
`endif
        input  fetch_en, fetch_addr, prog_start, prog_base, prog_valid, prog_data, prog_last,
        output fetch_data, fetch_valid, cpu_hold, prog_ready, prog_done, prog_wrap, prog_csum
    );

endinterface

// File: rtl/prog_mem_array.sv
// Single-port synchronous RAM with registered read data, inferable as block RAM.
module prog_mem_array #(
    parameter int unsigned WIDTH  = 14,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Output register keeps its value unless a read is issued; reset maps to the RAM output reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_mem_rw.sv
// Loadable instruction memory: clears to CLR_VAL after reset, serves fetches, accepts load sessions.
// Optional per-word even parity with fetch_perr when PROG_MEM_PARITY_EN is defined.
module prog_mem_rw
    import prog_mem_pkg::*;
#(
    parameter int unsigned       DATA_W  = DEF_DATA_W,
    parameter int unsigned       ADDR_W  = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] CLR_VAL = DATA_W'(NOP)
) (
    input  logic         clk,
    input  logic         rst,
    prog_mem_rw_if.slave bus
);

`ifdef PROG_MEM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic              wrap_q, wrap_d;
    logic              done_q, done_d;
    logic              hold_q;
    logic              ready_q;
    logic              fvalid_q, fvalid_d;

    logic              mem_we_c;
    logic              mem_re_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] wdata_c;
    logic [MEM_W-1:0]  mem_wdata_c;
    logic [MEM_W-1:0]  mem_rdata;

    // Next-state, pointer, checksum and memory-port control.
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        ld_ptr_d   = ld_ptr_q;
        csum_d     = csum_q;
        wrap_d     = wrap_q;
        done_d     = 1'b0;
        fvalid_d   = 1'b0;
        mem_we_c   = 1'b0;
        mem_re_c   = 1'b0;
        mem_addr_c = bus.fetch_addr;
        wdata_c    = CLR_VAL;

        unique case (state_q)
            ST_CLEAR: begin
                mem_we_c   = 1'b1;
                mem_addr_c = clr_ptr_q;
                clr_ptr_d  = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A load request wins over a same-cycle fetch.
                if (bus.prog_start) begin
                    state_d  = ST_LOAD;
                    ld_ptr_d = bus.prog_base;
                    csum_d   = '0;
                    wrap_d   = 1'b0;
                end else if (bus.fetch_en) begin
                    mem_re_c = 1'b1;
                    fvalid_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (bus.prog_valid && ready_q) begin
                    mem_we_c   = 1'b1;
                    mem_addr_c = ld_ptr_q;
                    wdata_c    = bus.prog_data;
                    ld_ptr_d   = ld_ptr_q + ADDR_W'(1);
                    csum_d     = csum_q + bus.prog_data;
                    if (ld_ptr_q == '1) begin
                        wrap_d = 1'b1;
                    end
                    if (bus.prog_last) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

`ifdef PROG_MEM_PARITY_EN
    assign mem_wdata_c = {even_par(64'(wdata_c)), wdata_c};
`else
    assign mem_wdata_c = wdata_c;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            ld_ptr_q  <= '0;
            csum_q    <= '0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            hold_q    <= 1'b1;
            ready_q   <= 1'b0;
            fvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ld_ptr_q  <= ld_ptr_d;
            csum_q    <= csum_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
            hold_q    <= (state_d != ST_RUN);
            ready_q   <= (state_d == ST_LOAD);
            fvalid_q  <= fvalid_d;
        end
    end

    prog_mem_array #(
        .WIDTH  (MEM_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we_c & ~rst),
        .re_i    (mem_re_c & ~rst),
        .addr_i  (mem_addr_c),
        .wdata_i (mem_wdata_c),
        .rdata_o (mem_rdata)
    );

    assign bus.fetch_data  = mem_rdata[DATA_W-1:0];
    assign bus.fetch_valid = fvalid_q;
    assign bus.cpu_hold    = hold_q;
    assign bus.prog_ready  = ready_q;
    assign bus.prog_done   = done_q;
    assign bus.prog_wrap   = wrap_q;
    assign bus.prog_csum   = csum_q;

`ifdef PROG_MEM_PARITY_EN
    // Stored word plus its parity bit must XOR to zero; flag only alongside a valid fetch.
    assign bus.fetch_perr = fvalid_q & (^mem_rdata);
`endif

endmodule

// File: tb/tb_prog_mem_rw.sv
// Randomized self-checking bench for prog_mem_rw against an array-based reference model.
module tb_prog_mem_rw;

    localparam int DW    = 14;
    localparam int AW    = 11;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_mem_rw_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    prog_mem_rw #(.DATA_W(DW), .ADDR_W(AW), .CLR_VAL('0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_csum;
    logic          exp_wrap;
    logic [DW-1:0] last_fetch;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.fetch_en   = 1'b0;
        bus.fetch_addr = '0;
        bus.prog_start = 1'b0;
        bus.prog_base  = '0;
        bus.prog_valid = 1'b0;
        bus.prog_data  = '0;
        bus.prog_last  = 1'b0;
    endtask

    // Release reset and measure how long the core is held while memory clears.
    task automatic release_and_clear();
        int n;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        rst = 1'b0;
        n = 0;
        while (bus.cpu_hold && n < 3 * DEPTH) begin
            n++;
            step();
        end
        chk("clear_len", n, DEPTH);
        chk("clear_ready", bus.prog_ready, 0);
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = a;
        step();
        bus.fetch_en = 1'b0;
        chk("fetch_valid", bus.fetch_valid, 1);
        chk($sformatf("fetch_data[%0h]", a), bus.fetch_data, model[a]);
`ifdef PROG_MEM_PARITY_EN
        chk("fetch_perr", bus.fetch_perr, 0);
`endif
        last_fetch = model[a];
    endtask

    // Load session; gaps between words are random, a stray prog_start mid-session must be ignored.
    task automatic load(input logic [AW-1:0] base, input logic [DW-1:0] words[$]);
        int a;
        a = int'(base);
        exp_csum = '0;
        exp_wrap = 1'b0;
        bus.prog_start = 1'b1;
        bus.prog_base  = base;
        step();
        bus.prog_start = 1'b0;
        chk("load_hold", bus.cpu_hold, 1);
        chk("load_ready", bus.prog_ready, 1);
        chk("load_fdata_held", bus.fetch_data, last_fetch);
        foreach (words[i]) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                bus.prog_start = ($urandom_range(0, 3) == 0);
                bus.prog_base  = AW'($urandom);
                step();
                bus.prog_start = 1'b0;
            end
            bus.prog_valid = 1'b1;
            bus.prog_data  = words[i];
            bus.prog_last  = (i == words.size() - 1);
            step();
            bus.prog_valid = 1'b0;
            bus.prog_last  = 1'b0;
            model[a] = words[i];
            exp_csum = DW'(exp_csum + words[i]);
            if (a == DEPTH - 1) exp_wrap = 1'b1;
            a = (a + 1) % DEPTH;
            chk("load_done", bus.prog_done, (i == words.size() - 1));
        end
        chk("end_ready", bus.prog_ready, 0);
        chk("end_hold", bus.cpu_hold, 0);
        chk("csum", bus.prog_csum, exp_csum);
        chk("wrap", bus.prog_wrap, exp_wrap);
        step();
        chk("done_pulse", bus.prog_done, 0);
    endtask

    initial begin
        logic [DW-1:0] w[$];
        idle_inputs();
        last_fetch = '0;
        rst = 1'b1;
        repeat (3) step();
        chk("rst_fdata", bus.fetch_data, 0);
        chk("rst_fvalid", bus.fetch_valid, 0);
        chk("rst_hold", bus.cpu_hold, 1);
        chk("rst_ready", bus.prog_ready, 0);
        chk("rst_done", bus.prog_done, 0);
        chk("rst_wrap", bus.prog_wrap, 0);
        chk("rst_csum", bus.prog_csum, 0);
        release_and_clear();

        fetch(AW'(DEPTH - 1));
        step();
        chk("nofetch_valid", bus.fetch_valid, 0);

        w = '{14'h01A5, 14'h01A4, 14'h3007};
        load('0, w);
        chk("csum_const", bus.prog_csum, 14'h3350);
        for (int i = 0; i < 3; i++) fetch(AW'(i));

        w = '{DW'($urandom), DW'($urandom), DW'($urandom)};
        load(AW'(DEPTH - 2), w);
        fetch(AW'(DEPTH - 2));
        fetch(AW'(DEPTH - 1));
        fetch('0);
        chk("wrap_sticky", bus.prog_wrap, 1);

        // Load request and fetch in the same cycle: fetch is dropped.
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = AW'(5);
        bus.prog_start = 1'b1;
        bus.prog_base  = AW'(100);
        step();
        idle_inputs();
        chk("race_fvalid", bus.fetch_valid, 0);
        chk("race_hold", bus.cpu_hold, 1);
        chk("race_ready", bus.prog_ready, 1);
        bus.prog_valid = 1'b1;
        bus.prog_data  = 14'h2AAA;
        bus.prog_last  = 1'b1;
        step();
        idle_inputs();
        model[100] = 14'h2AAA;
        chk("race_done", bus.prog_done, 1);
        chk("race_csum", bus.prog_csum, 14'h2AAA);
        fetch(AW'(100));

        // Random sessions and random fetches against the model.
        for (int s = 0; s < 6; s++) begin
            int len;
            w = {};
            len = int'($urandom_range(1, 8));
            for (int k = 0; k < len; k++) w.push_back(DW'($urandom));
            load(AW'($urandom), w);
            for (int f = 0; f < 6; f++) begin
                if ($urandom_range(0, 3) == 0) begin
                    step();
                    chk("rand_idle_valid", bus.fetch_valid, 0);
                end else begin
                    fetch(AW'($urandom));
                end
            end
            chk("csum_hold", bus.prog_csum, exp_csum);
            chk("wrap_hold", bus.prog_wrap, exp_wrap);
        end

        // Reset in the middle of a session restarts the clear.
        bus.prog_start = 1'b1;
        bus.prog_base  = AW'(300);
        step();
        bus.prog_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.prog_valid = 1'b1;
            bus.prog_data  = DW'($urandom_range(1, 16383));
            step();
        end
        idle_inputs();
        rst = 1'b1;
        step();
        chk("midrst_hold", bus.cpu_hold, 1);
        chk("midrst_csum", bus.prog_csum, 0);
        chk("midrst_ready", bus.prog_ready, 0);
        release_and_clear();
        fetch(AW'(301));
        fetch(AW'(300));

`ifdef PROG_MEM_PARITY_EN
        u_dut.u_array.mem_q[16][3] = ~u_dut.u_array.mem_q[16][3];
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = AW'(16);
        step();
        bus.fetch_en = 1'b0;
        chk("perr_flip", bus.fetch_perr, 1);
        chk("perr_data", bus.fetch_data, 14'h0008);
        fetch(AW'(17));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
